// File: rtl/dht11_pkg.sv
// Shared constants, state encodings and frame payload for the DHT11 responder emulator.
package dht11_pkg;

  localparam int unsigned CLK_PER_US_DEF   = 100;
  localparam int unsigned START_MIN_US_DEF = 16000;
  localparam int unsigned RESP_DLY_US_DEF  = 30;
  localparam int unsigned RESP_L_US_DEF    = 80;
  localparam int unsigned RESP_H_US_DEF    = 80;
  localparam int unsigned BIT_L_US_DEF     = 50;
  localparam int unsigned BIT0_H_US_DEF    = 26;
  localparam int unsigned BIT1_H_US_DEF    = 70;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned US_CNT_W   = 15;
  localparam int unsigned BIT_IDX_W  = 6;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_HOST_LOW = 3'd1;
  localparam logic [STATE_W-1:0] ST_DLY      = 3'd2;
  localparam logic [STATE_W-1:0] ST_RESP_L   = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP_H   = 3'd4;
  localparam logic [STATE_W-1:0] ST_BIT_L    = 3'd5;
  localparam logic [STATE_W-1:0] ST_BIT_H    = 3'd6;
  localparam logic [STATE_W-1:0] ST_EOF_L    = 3'd7;

  // Transmitted order, MSB first on the wire.
  typedef struct packed {
    logic [7:0] rh_int;
    logic [7:0] rh_dec;
    logic [7:0] t_int;
    logic [7:0] t_dec;
    logic [7:0] cs;
  } dht11_frame_t;

  function automatic logic [7:0] dht11_checksum(input logic [7:0] rh_int, input logic [7:0] rh_dec,
                                                input logic [7:0] t_int, input logic [7:0] t_dec);
    return 8'(rh_int + rh_dec + t_int + t_dec);
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// Parallel side of the DHT11 emulator: sensor bytes in, status out.
// DHT11_EMU_ERR_INJ_EN adds the cs_corrupt checksum error-injection input.
interface dht11_sensor_emu_if;
  import dht11_pkg::*;

  logic [7:0]         rh_int;
  logic [7:0]         rh_dec;
  logic [7:0]         t_int;
  logic [7:0]         t_dec;
`ifdef DHT11_EMU_ERR_INJ_EN
  logic               cs_corrupt;
`endif
  logic               busy;
  logic               frame_done;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    output rh_int, rh_dec, t_int, t_dec,
`ifdef DHT11_EMU_ERR_INJ_EN
    output cs_corrupt,
`endif
    input  busy, frame_done, state_dbg
  );

  modport slave (
    input  rh_int, rh_dec, t_int, t_dec,
`ifdef DHT11_EMU_ERR_INJ_EN
    input  cs_corrupt,
`endif
    output busy, frame_done, state_dbg
  );

endinterface

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler; clr restarts the count so every phase starts on a clean us boundary.
module us_tick_gen #(
  parameter int unsigned CLK_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (clr || (pre_q == PRE_LAST)) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign tick = (pre_q == PRE_LAST);

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 responder: detects the host start pulse, answers with the handshake and a 40-bit frame.
// Optional DHT11_EMU_ERR_INJ_EN: emu.cs_corrupt flips checksum bit 0 when high at the latch point.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US   = CLK_PER_US_DEF,
  parameter int unsigned START_MIN_US = START_MIN_US_DEF,
  parameter int unsigned RESP_DLY_US  = RESP_DLY_US_DEF,
  parameter int unsigned RESP_L_US    = RESP_L_US_DEF,
  parameter int unsigned RESP_H_US    = RESP_H_US_DEF,
  parameter int unsigned BIT_L_US     = BIT_L_US_DEF,
  parameter int unsigned BIT0_H_US    = BIT0_H_US_DEF,
  parameter int unsigned BIT1_H_US    = BIT1_H_US_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  dht11_sensor_emu_if.slave        emu,
  inout  wire                      dht11_io
);

  localparam logic [US_CNT_W-1:0]  START_MIN_CNT = US_CNT_W'(START_MIN_US);
  localparam logic [US_CNT_W-1:0]  DLY_LAST      = US_CNT_W'(RESP_DLY_US - 1);
  localparam logic [US_CNT_W-1:0]  RESP_L_LAST   = US_CNT_W'(RESP_L_US - 1);
  localparam logic [US_CNT_W-1:0]  RESP_H_LAST   = US_CNT_W'(RESP_H_US - 1);
  localparam logic [US_CNT_W-1:0]  BIT_L_LAST    = US_CNT_W'(BIT_L_US - 1);
  localparam logic [US_CNT_W-1:0]  BIT0_H_LAST   = US_CNT_W'(BIT0_H_US - 1);
  localparam logic [US_CNT_W-1:0]  BIT1_H_LAST   = US_CNT_W'(BIT1_H_US - 1);
  localparam logic [US_CNT_W-1:0]  US_CNT_MAX    = '1;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT      = BIT_IDX_W'(FRAME_BITS - 1);

  logic                  sync1_q, sync1_d;
  logic                  io_s_q, io_s_d;
  logic                  io_prev_q, io_prev_d;
  logic [STATE_W-1:0]    state_q, state_d;
  logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic                  drive_low_q, drive_low_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick_c;
  logic                  clr_c;
  logic                  fall_c;
  logic                  rise_c;
  logic                  phase_done_c;
  logic [US_CNT_W-1:0]   phase_last_c;
  logic [7:0]            cs_c;
  dht11_frame_t          frame_c;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .tick (tick_c)
  );

`ifdef DHT11_EMU_ERR_INJ_EN
  assign cs_c = dht11_checksum(emu.rh_int, emu.rh_dec, emu.t_int, emu.t_dec) ^ {7'd0, emu.cs_corrupt};
`else
  assign cs_c = dht11_checksum(emu.rh_int, emu.rh_dec, emu.t_int, emu.t_dec);
`endif

  assign frame_c = {emu.rh_int, emu.rh_dec, emu.t_int, emu.t_dec, cs_c};
  assign fall_c  = io_prev_q & ~io_s_q;
  assign rise_c  = ~io_prev_q & io_s_q;

  // Duration (in us, minus one) of the phase the FSM is currently in.
  always_comb begin
    phase_last_c = BIT_L_LAST;
    case (state_q)
      ST_DLY:    phase_last_c = DLY_LAST;
      ST_RESP_L: phase_last_c = RESP_L_LAST;
      ST_RESP_H: phase_last_c = RESP_H_LAST;
      ST_BIT_H:  phase_last_c = shreg_q[FRAME_BITS-1] ? BIT1_H_LAST : BIT0_H_LAST;
      default:   phase_last_c = BIT_L_LAST;
    endcase
  end

  assign phase_done_c = tick_c && (us_cnt_q == phase_last_c);

  always_comb begin
    sync1_d      = dht11_io;
    io_s_d       = sync1_q;
    io_prev_d    = io_s_q;
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    frame_done_d = 1'b0;
    clr_c        = 1'b0;
    drive_low_d  = 1'b0;
    busy_d       = 1'b0;
    us_cnt_d     = us_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (fall_c) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        // A too-short host pulse is dropped silently.
        if (rise_c) begin
          if (us_cnt_q >= START_MIN_CNT) begin
            state_d   = ST_DLY;
            shreg_d   = frame_c;
            bit_idx_d = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DLY: begin
        if (phase_done_c) state_d = ST_RESP_L;
      end
      ST_RESP_L: begin
        if (phase_done_c) state_d = ST_RESP_H;
      end
      ST_RESP_H: begin
        if (phase_done_c) state_d = ST_BIT_L;
      end
      ST_BIT_L: begin
        if (phase_done_c) state_d = ST_BIT_H;
      end
      ST_BIT_H: begin
        if (phase_done_c) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d   = ST_EOF_L;
          end else begin
            state_d   = ST_BIT_L;
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      ST_EOF_L: begin
        if (phase_done_c) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Restart timing on every state entry so phase widths are exact multiples of CLK_PER_US.
    clr_c       = (state_d != state_q);
    drive_low_d = (state_d == ST_RESP_L) || (state_d == ST_BIT_L) || (state_d == ST_EOF_L);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HOST_LOW);

    if (clr_c) begin
      us_cnt_d = '0;
    end else if (tick_c && (us_cnt_q != US_CNT_MAX)) begin
      us_cnt_d = us_cnt_q + US_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      io_s_q       <= 1'b1;
      io_prev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      us_cnt_q     <= '0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      drive_low_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      io_s_q       <= io_s_d;
      io_prev_q    <= io_prev_d;
      state_q      <= state_d;
      us_cnt_q     <= us_cnt_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      drive_low_q  <= drive_low_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign emu.busy       = busy_q;
  assign emu.frame_done = frame_done_q;
  assign emu.state_dbg  = state_q;

  // Open-drain: only ever pull low, the external pull-up provides the high level.
  assign dht11_io = drive_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Self-checking bench for dht11_sensor_emu: host model on a pulled-up line, frame decoder and timing checks.
`timescale 1ns/1ps
module tb_dht11_sensor_emu;

  localparam int unsigned CPU       = 2;
  localparam int unsigned START_MIN = 160;
  // Host release reaches the FSM through a 2-FF synchronizer plus the edge-detect register.
  localparam int          SYNC_LAT  = 3;
  localparam int          RUN_LIMIT = 200 * CPU;

  logic clk = 1'b0;
  logic rst;
  logic host_low;
  wire  dht11_io;

  pullup (dht11_io);
  assign dht11_io = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emu_if emu_if ();

  dht11_sensor_emu #(.CLK_PER_US(CPU), .START_MIN_US(START_MIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .emu      (emu_if),
    .dht11_io (dht11_io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  always @(negedge clk) if (emu_if.frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: four data bytes then their sum modulo 256, optionally with bit 0 flipped.
  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d, input bit corrupt);
    int sum;
    logic [7:0] cs;
    sum = int'(a) + int'(b) + int'(c) + int'(d);
    cs  = 8'(sum % 256);
    if (corrupt) cs = cs ^ 8'h01;
    return {a, b, c, d, cs};
  endfunction

  task automatic set_data(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    emu_if.rh_int = a;
    emu_if.rh_dec = b;
    emu_if.t_int  = c;
    emu_if.t_dec  = d;
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while ((dht11_io === lvl) && (n < RUN_LIMIT)) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic host_pulse(input int host_us);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (host_us * CPU) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int host_us, input int chg_bit, input logic [7:0] chg_val,
                           input int abort_bit, input bit corrupt);
    logic [39:0] exp_bits;
    logic [39:0] got_bits;
    int n;
    int fd0;
`ifdef DHT11_EMU_ERR_INJ_EN
    emu_if.cs_corrupt = corrupt;
`endif
    exp_bits = model_frame(emu_if.rh_int, emu_if.rh_dec, emu_if.t_int, emu_if.t_dec, corrupt);
    got_bits = '0;
    fd0      = fd_cnt;

    host_pulse(host_us);
    chk("state_host_low", emu_if.state_dbg, 1);
    host_low = 1'b0;
    @(negedge clk);

    run_len(1'b1, n);
    chk("resp_dly", n, 30 * CPU + SYNC_LAT);
    chk("busy_in_frame", emu_if.busy, 1);
    run_len(1'b0, n);
    chk("resp_low", n, 80 * CPU);
    run_len(1'b1, n);
    chk("resp_high", n, 80 * CPU);

    for (int i = 0; i < 40; i++) begin
      if (i == abort_bit) begin
        @(posedge clk);
        #1 chk("pre_rst_line", dht11_io, 0);
        rst = 1'b1;
        #1;
        chk("rst_line", dht11_io, 1);
        chk("rst_busy", emu_if.busy, 0);
        chk("rst_state", emu_if.state_dbg, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_frame_done", fd_cnt - fd0, 0);
        return;
      end
      if (i == chg_bit) emu_if.rh_int = chg_val;
      run_len(1'b0, n);
      chk($sformatf("bit%0d_low", i), n, 50 * CPU);
      run_len(1'b1, n);
      got_bits[39-i] = (n > 48 * CPU);
      chk($sformatf("bit%0d_high", i), n, exp_bits[39-i] ? 70 * CPU : 26 * CPU);
    end

    run_len(1'b0, n);
    chk("eof_low", n, 50 * CPU);
    repeat (3) @(negedge clk);
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("busy_after", emu_if.busy, 0);
    chk("state_after", emu_if.state_dbg, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("byte%0d", k), got_bits[39-8*k -: 8], exp_bits[39-8*k -: 8]);
    end
  endtask

  task automatic short_start(input int host_us);
    int lows;
    int busys;
    lows  = 0;
    busys = 0;
    host_pulse(host_us);
    host_low = 1'b0;
    repeat (200 * CPU) begin
      @(negedge clk);
      if (dht11_io !== 1'b1) lows++;
      if (emu_if.busy !== 1'b0) busys++;
    end
    chk("short_no_drive", lows, 0);
    chk("short_busy", busys, 0);
    chk("short_state", emu_if.state_dbg, 0);
  endtask

  function automatic int valid_us();
    return int'(START_MIN) + int'($urandom_range(10, 60));
  endfunction

  initial begin
    rst      = 1'b1;
    host_low = 1'b0;
    set_data(8'd0, 8'd0, 8'd0, 8'd0);
`ifdef DHT11_EMU_ERR_INJ_EN
    emu_if.cs_corrupt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_line", dht11_io, 1);
    chk("reset_busy", emu_if.busy, 0);
    chk("reset_frame_done", emu_if.frame_done, 0);
    chk("reset_state", emu_if.state_dbg, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    set_data(8'd55, 8'd0, 8'd24, 8'd0);
    run_frame(int'(START_MIN) + 20, -1, 8'd0, -1, 1'b0);

    short_start(int'($urandom_range(20, START_MIN - 20)));

    set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_frame(valid_us(), -1, 8'd0, -1, 1'b0);

    set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_frame(valid_us(), -1, 8'd0, 20, 1'b0);
    set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_frame(valid_us(), -1, 8'd0, -1, 1'b0);

    set_data(8'd55, 8'($urandom), 8'($urandom), 8'($urandom));
    run_frame(valid_us(), 10, 8'd99, -1, 1'b0);
    run_frame(valid_us(), -1, 8'd0, -1, 1'b0);

`ifdef DHT11_EMU_ERR_INJ_EN
    set_data(8'd55, 8'd0, 8'd24, 8'd0);
    run_frame(valid_us(), -1, 8'd0, -1, 1'b1);
    emu_if.cs_corrupt = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
